// File: rtl/picosoc_mem_arbiter.sv
// rtl/picosoc_mem_arbiter.sv - two-master arbiter in front of the single-port SoC SRAM
//
// Purpose: shares a 32-bit, byte-write-enabled, 1-cycle-read SRAM between the
// CPU RAM request (m0) and a secondary master (m1). One transaction is in
// flight at a time: IDLE -> ACCESS -> RESP -> IDLE. Round-robin by default;
// FIXED_PRIO=1 makes m0 win every tie.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   mN_valid/addr/wdata/wstrb request from master N (wstrb == 0 means read)
//   mN_ready/rdata           single-cycle completion pulse and read data
//   ram_wen/addr/wdata       SRAM write enables, word address, write data
//   ram_rdata                SRAM read data, valid the cycle after the address
//   grant                    one-hot owner of the current transaction
//   busy                     high whenever a transaction is in progress
module picosoc_mem_arbiter #(
  parameter int WORDS      = 256,
  parameter int AW         = 22,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic [31:0]   m0_rdata,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic [31:0]   m1_rdata,
  output logic [3:0]    ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0] state_q, state_d;
  logic       gnt_sel_q, gnt_sel_d;  // 0 = m0, 1 = m1
  logic       last_q, last_d;        // master granted most recently
  logic       pick;
  logic       in_access, in_resp;

  always_comb begin
    state_d   = state_q;
    gnt_sel_d = gnt_sel_q;
    last_d    = last_q;
    pick      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A lone requester wins outright; a tie goes to the master that was
        // not served last, or always to m0 in fixed-priority mode.
        if (m0_valid && m1_valid) begin
          pick = FIXED_PRIO ? 1'b0 : ~last_q;
        end else begin
          pick = m1_valid;
        end
        if (m0_valid || m1_valid) begin
          gnt_sel_d = pick;
          last_d    = pick;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_sel_q <= 1'b0;
      last_q    <= 1'b1;  // so m0 wins the first tie after reset
    end else begin
      state_q   <= state_d;
      gnt_sel_q <= gnt_sel_d;
      last_q    <= last_d;
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  // All outputs decode straight from the registered state, so an async reset
  // drops write enables, ready and busy without waiting for a clock edge.
  assign ram_addr  = gnt_sel_q ? m1_addr[AW+1:2] : m0_addr[AW+1:2];
  assign ram_wdata = gnt_sel_q ? m1_wdata : m0_wdata;
  assign ram_wen   = in_access ? (gnt_sel_q ? m1_wstrb : m0_wstrb) : 4'b0000;

  assign m0_ready  = in_resp && !gnt_sel_q;
  assign m1_ready  = in_resp &&  gnt_sel_q;
  assign m0_rdata  = m0_ready ? ram_rdata : 32'h0;
  assign m1_rdata  = m1_ready ? ram_rdata : 32'h0;

  assign busy      = (state_q != ST_IDLE);
  assign grant     = busy ? (gnt_sel_q ? 2'b10 : 2'b01) : 2'b00;

  // Byte-offset and above-window address bits are intentionally ignored.
  logic unused_addr_parity;
  assign unused_addr_parity = ^{m0_addr, m1_addr};

  // Catch masters addressing beyond the physical RAM depth.
  always_ff @(posedge clk) begin
    if (!reset && in_access) begin
      assert (int'(ram_addr) < WORDS);
    end
  end

endmodule

// File: tb/tb_picosoc_mem_arbiter.sv
// tb/tb_picosoc_mem_arbiter.sv - scoreboard bench for picosoc_mem_arbiter
module tb_picosoc_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  ram_wen;
  logic [21:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [1:0]  grant;
  logic        busy;

  logic        m0_ready_b, m1_ready_b;
  logic [31:0] m0_rdata_b, m1_rdata_b;
  logic [3:0]  ram_wen_b;
  logic [21:0] ram_addr_b;
  logic [31:0] ram_wdata_b;
  logic [31:0] ram_rdata_b;
  logic [1:0]  grant_b;
  logic        busy_b;

  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;
  logic [31:0] mem_a [0:255];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        mst;
    logic        chk;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  picosoc_mem_arbiter #(.WORDS(256), .AW(22), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .grant(grant), .busy(busy)
  );

  picosoc_mem_arbiter #(.WORDS(256), .AW(22), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready_b), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata_b),
    .m1_valid(m1_valid), .m1_ready(m1_ready_b), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata_b),
    .ram_wen(ram_wen_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
    .ram_rdata(ram_rdata_b), .grant(grant_b), .busy(busy_b)
  );

  assign ram_rdata_b = 32'h0;
  wire unused_tb = ^{ram_addr[21:8], m0_rdata_b, m1_rdata_b, ram_wen_b,
                     ram_addr_b, ram_wdata_b, grant_b, busy_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural picosoc_mem-style SRAM with a backdoor write port.
  always @(posedge clk) begin
    if (bd_we) begin
      mem_a[bd_addr] <= bd_data;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ram_wen[i]) mem_a[ram_addr[7:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    ram_rdata <= mem_a[ram_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (m0_ready || m1_ready)) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_master", 32'(m1_ready), 32'(e.mst));
        if (e.chk) check("sb_rdata", e.mst ? m1_rdata : m0_rdata, e.rdata);
        check("sb_other_rdata", e.mst ? m0_rdata : m1_rdata, 32'h0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic mst, input logic chk, input logic [31:0] d);
    exp_t x;
    x.mst = mst; x.chk = chk; x.rdata = d;
    exp_q.push_back(x);
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    cyc(1);
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  int  wen_cycles;
  logic exp_m, is_resp, is_acc, found;

  initial begin
    reset = 1'b0; bd_we = 1'b0; bd_addr = 8'h0; bd_data = 32'h0;
    m0_valid = 1'b0; m1_valid = 1'b0;
    m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
    m0_wstrb = 4'h0; m1_wstrb = 4'h0;

    // Reset values appear before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_wen", 32'(ram_wen), 32'd0);
    check("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
    do_reset();

    bd_write(8'd5, 32'hDEADBEEF);
    bd_write(8'd2, 32'hAAAAAAAA);
    bd_write(8'd7, 32'h12345678);

    // Single read by m0.
    m0_addr = 32'h14; m0_wstrb = 4'h0; m0_valid = 1'b1;
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    check("rd_idle_busy", 32'(busy), 32'd0);
    cyc(1);
    check("rd_ram_addr", 32'(ram_addr), 32'd5);
    check("rd_grant", 32'(grant), 32'd1);
    check("rd_busy", 32'(busy), 32'd1);
    cyc(1);
    check("rd_ready", 32'(m0_ready), 32'd1);
    check("rd_rdata", m0_rdata, 32'hDEADBEEF);
    m0_valid = 1'b0;
    cyc(1);
    check("rd_done_busy", 32'(busy), 32'd0);

    // Byte write by m1 into word 2.
    m1_addr = 32'h08; m1_wdata = 32'h11223344; m1_wstrb = 4'b0010; m1_valid = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0);
    wen_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      if (ram_wen != 4'b0) begin
        wen_cycles++;
        check("wr_wen", 32'(ram_wen), 32'b0010);
      end
      check("wr_m0_quiet", 32'(m0_ready), 32'd0);
      if (c == 2) begin
        check("wr_m1_ready", 32'(m1_ready), 32'd1);
        m1_valid = 1'b0;
      end
      cyc(1);
    end
    check("wr_wen_cycles", 32'(wen_cycles), 32'd1);
    check("wr_mem", mem_a[2], 32'hAAAA33AA);
    m0_addr = 32'h08; m0_valid = 1'b1;
    push_exp(1'b0, 1'b1, 32'hAAAA33AA);
    cyc(2);
    check("wr_readback", m0_rdata, 32'hAAAA33AA);
    m0_valid = 1'b0;
    cyc(1);
    check("wr_drain", 32'(exp_q.size()), 32'd0);

    // Both masters continuously requesting after reset.
    do_reset();
    m0_addr = 32'h14; m0_wstrb = 4'h0; m1_addr = 32'h08; m1_wstrb = 4'h0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int t = 0; t < 6; t++) begin
      push_exp(t[0], 1'b1, t[0] ? 32'hAAAA33AA : 32'hDEADBEEF);
    end
    for (int c = 0; c < 18; c++) begin
      exp_m   = ((c / 3) % 2) == 1;
      is_resp = (c % 3) == 2;
      is_acc  = (c % 3) == 1;
      check("rr_m0_ready", 32'(m0_ready), 32'(is_resp && !exp_m));
      check("rr_m1_ready", 32'(m1_ready), 32'(is_resp && exp_m));
      if (is_acc) check("rr_grant", 32'(grant), exp_m ? 32'd2 : 32'd1);
      check("fp_m0_ready", 32'(m0_ready_b), 32'(is_resp));
      check("fp_m1_ready", 32'(m1_ready_b), 32'd0);
      cyc(1);
    end
    // Fixed priority: m1 is served once m0 stops asking.
    m0_valid = 1'b0;
    push_exp(1'b1, 1'b1, 32'hAAAA33AA);
    found = 1'b0;
    for (int k = 0; k < 3 && !found; k++) begin
      cyc(1);
      if (m1_ready_b) found = 1'b1;
    end
    check("fp_m1_after_drop", 32'(found), 32'd1);
    m1_valid = 1'b0;
    cyc(2);
    check("rr_drain", 32'(exp_q.size()), 32'd0);

    // Async reset in the middle of an m0 write ACCESS.
    m0_addr = 32'h1C; m0_wdata = 32'hCAFEF00D; m0_wstrb = 4'b1111; m0_valid = 1'b1;
    cyc(1);
    check("rst_mid_wen_pre", 32'(ram_wen), 32'hF);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_wen", 32'(ram_wen), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    m0_valid = 1'b0;
    cyc(2);
    reset = 1'b0;
    check("rst_mid_mem", mem_a[7], 32'h12345678);
    m0_addr = 32'h14; m0_wstrb = 4'h0; m1_addr = 32'h08; m1_wstrb = 4'h0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    push_exp(1'b1, 1'b1, 32'hAAAA33AA);
    cyc(2);
    check("tie_after_rst_m0", 32'(m0_ready), 32'd1);
    check("tie_after_rst_m1", 32'(m1_ready), 32'd0);
    m0_valid = 1'b0;
    cyc(3);
    check("tie_after_rst_m1_late", 32'(m1_ready), 32'd1);
    m1_valid = 1'b0;
    cyc(1);

    // m1 withdraws valid during ACCESS; transaction still completes once.
    m1_addr = 32'h14; m1_valid = 1'b1;
    push_exp(1'b1, 1'b1, 32'hDEADBEEF);
    cyc(1);
    m1_valid = 1'b0;
    cyc(1);
    check("pv_ready", 32'(m1_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      cyc(1);
      check("pv_idle_busy", 32'(busy), 32'd0);
    end
    check("pv_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/picosoc_mem_arbiter.md
Name: picosoc_mem_arbiter

Overview:
- Shares the single-port on-chip SRAM (picosoc_mem-style: 32-bit, byte write enables, 1-cycle synchronous read) between two native-bus masters.
- m0 is the CPU-side RAM request (already address-decoded); m1 is a secondary master (DMA/video fetch).
- Round-robin arbitration with registered grant and one transaction in flight; a parameter selects fixed m0 priority instead.

Parameters:
- WORDS, 256, RAM depth in 32-bit words; only used for the ram_addr width check in simulation.
- AW, 22, ram_addr width (word address = mN_addr[AW+1:2]).
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins ties.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_valid  in  1  master 0 request; held until m0_ready
- m0_ready  out  1  single-cycle completion pulse
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_wstrb  in  4  byte strobes; 0 = read
- m0_rdata  out  32  read data, valid while m0_ready=1
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata  as m0
- ram_wen  out  4  RAM byte write enables
- ram_addr  out  AW  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after the address
- grant  out  2  one-hot owner of the current transaction; 00 when IDLE
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (async): state=IDLE, gnt_sel=0, last=1 (so m0 wins the first tie), m0_ready=m1_ready=0, ram_wen=0, grant=00, busy=0. Outputs reach these values immediately on assertion, without waiting for a clock edge.
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If no valid, stay in IDLE.
  - If exactly one valid, latch that master in gnt_sel and go to ACCESS.
  - If both valid: with FIXED_PRIO=0 pick the master != last; with FIXED_PRIO=1 pick m0.
  - On a grant, set last := the granted master.
- ACCESS (1 cycle):
  - ram_addr = granted mN_addr[AW+1:2], ram_wdata = mN_wdata, ram_wen = mN_wstrb.
  - RAM captures the write, or launches the read, at the end of this cycle.
  - Next state is RESP.
- RESP (1 cycle):
  - Granted mN_ready=1 and mN_rdata=ram_rdata (combinational pass-through).
  - ram_wen=0. Next state is IDLE.
- Outside ACCESS, ram_wen=0; ram_addr and ram_wdata hold the mux of gnt_sel (don't-care values).
- Non-granted mN_ready is always 0; non-granted mN_rdata=0.
- Latency: valid seen in IDLE at cycle N -> mN_ready at cycle N+2. Minimum period is 3 cycles per transaction, so peak throughput is 1/3.
- Masters drop valid in the cycle after ready. In the IDLE cycle that follows RESP, the arbiter re-samples both valids.
- Fairness (round-robin): with both masters continuously requesting, grants strictly alternate, and neither master waits more than one transaction.
- Valid withdrawn during ACCESS or RESP (protocol violation): the transaction still completes. Any write already issued in ACCESS is not undone, and the ready pulse is still emitted.
- Address/strobe changes during ACCESS are not captured; masters must hold them stable until ready.
- Reset mid-transaction: FSM aborts to IDLE and no ready is emitted. A write is suppressed if reset asserts before the ACCESS clock edge.
- grant mirrors gnt_sel one-hot in ACCESS and RESP.

Test Plan:
- Single read: preload RAM word 5 = 0xDEADBEEF; m0_valid=1, addr=0x14, wstrb=0 at cycle 0 -> ram_addr=5 at cycle 1, m0_ready=1 with m0_rdata=0xDEADBEEF at cycle 2, busy=0 at cycle 3.
- Byte write: m1 writes addr=0x08, wdata=0x11223344, wstrb=0b0010 over word 2 = 0xAAAAAAAA -> ram_wen=0b0010 for exactly one cycle; a subsequent read returns 0xAAAA33AA; m0_ready stays 0 throughout.
- Simultaneous requests after reset, FIXED_PRIO=0: both valid at cycle 0 -> m0 ready at cycle 2, m1 ready at cycle 5. Keep both requesting for 6 transactions -> grant sequence m0,m1,m0,m1,m0,m1.
- FIXED_PRIO=1 with both continuously valid -> m0 granted every time, m1 never granted; drop m0 -> m1 ready within 3 cycles.
- Reset asserted asynchronously mid-ACCESS of an m0 write -> ram_wen=0 and busy=0 before the next edge; target word unchanged; m0_ready never pulses; after release, the first tie goes to m0.
- Protocol violation: m1 drops valid in ACCESS -> m1_ready still pulses once at RESP; FSM returns to IDLE and no second transaction occurs.
